// File: rtl/fetch_pkg.sv
// Shared defaults and helpers for the instruction fetch queue.
package fetch_pkg;

    localparam int ADDR_W_DEF  = 32'sd32;
    localparam int INST_W_DEF  = 32'sd32;
    localparam int PC_STEP_DEF = 32'sd4;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Smallest r with 2**r >= value, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 32'sd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_chk.sv
// Protocol checks for fetch_queue_unit; assertion-only, no logic.
module fetch_chk #(
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             reset,
    input logic             resp_valid,
    input logic [CNT_W-1:0] inflight,
    input logic             push,
    input logic             pop,
    input logic             full
);

    a_resp_without_request: assert property (@(posedge clk) disable iff (!reset)
        !(resp_valid && (inflight == {CNT_W{1'b0}})));

    a_push_into_full: assert property (@(posedge clk) disable iff (!reset)
        (push && full) |-> pop);

endmodule

// File: rtl/fetch_fifo.sv
// In-order synchronous FIFO; a pop in the flush cycle still consumes the head.
module fetch_fifo import fetch_pkg::*; #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    localparam int CNT_W = clog2(DEPTH + 32'sd1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(32'd1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Next-state for storage, pointers and count.
    always_comb begin
        do_pop_s  = pop && (count_q != {CNT_W{1'b0}});
        do_push_s = push && ((count_q != FULL_CNT) || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            rd_ptr_d = do_pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: {W{1'b0}}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The head reads as zero when empty so decode never sees leftover data.
    assign rd_data = empty ? {W{1'b0}} : mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled fetch stage: sequential PC issue, in-order return queue, redirect flush.
module fetch_queue_unit import fetch_pkg::*; #(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                INST_W    = INST_W_DEF,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] INIT_ADDR = {ADDR_W{1'b0}},
    parameter int                PC_STEP   = PC_STEP_DEF,
    localparam int               CNT_W     = clog2(DEPTH + 32'sd1)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_plus8,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_A    = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] LINK_A    = ADDR_W'(2 * PC_STEP);
    localparam logic [ADDR_W-1:0] PC_MASK   = ~(STEP_A - ADDR_W'(32'd1));
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(32'd1);
    localparam logic [CNT_W:0]    DEPTH_SUM = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d, stale_q, stale_d;
    logic [PTR_W-1:0]  iss_ptr_q, iss_ptr_d, rsp_ptr_q, rsp_ptr_d;
    logic [ADDR_W-1:0] slot_pc_q [DEPTH];
    logic [ADDR_W-1:0] slot_pc_d [DEPTH];

    logic [CNT_W:0]           occ_sum_s;
    logic                     req_valid_s, accept_s, resp_ok_s, push_s, pop_s;
    logic [INST_W+ADDR_W-1:0] head_s;
    logic [CNT_W-1:0]         fifo_count_s;
    logic                     fifo_full_s, fifo_empty_s;

    // Issue is held off during reset, redirect, or when queue plus outstanding is full.
    assign occ_sum_s   = {1'b0, fifo_count_s} + {1'b0, inflight_q};
    assign req_valid_s = reset && !redirect_valid && (occ_sum_s < DEPTH_SUM);
    assign accept_s    = req_valid_s && imem_req_ready;
    assign resp_ok_s   = imem_resp_valid && (inflight_q != {CNT_W{1'b0}});
    assign push_s      = resp_ok_s && (stale_q == {CNT_W{1'b0}}) && !redirect_valid;
    assign pop_s       = !fifo_empty_s && out_ready;

    // PC, slot bookkeeping and outstanding/stale counters.
    always_comb begin
        slot_pc_d = slot_pc_q;
        if (accept_s) begin
            slot_pc_d[iss_ptr_q] = fetch_pc_q;
            iss_ptr_d            = iss_ptr_q + PTR_ONE;
        end else begin
            iss_ptr_d = iss_ptr_q;
        end
        rsp_ptr_d = resp_ok_s ? (rsp_ptr_q + PTR_ONE) : rsp_ptr_q;
        case ({accept_s, resp_ok_s})
            2'b10:   inflight_d = inflight_q + CNT_ONE;
            2'b01:   inflight_d = inflight_q - CNT_ONE;
            default: inflight_d = inflight_q;
        endcase
        // Everything still outstanding after a redirect belongs to the old stream.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & PC_MASK;
            stale_d    = inflight_d;
        end else begin
            fetch_pc_d = accept_s ? (fetch_pc_q + STEP_A) : fetch_pc_q;
            stale_d    = (resp_ok_s && (stale_q != {CNT_W{1'b0}})) ? (stale_q - CNT_ONE) : stale_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= INIT_ADDR;
            inflight_q <= {CNT_W{1'b0}};
            stale_q    <= {CNT_W{1'b0}};
            iss_ptr_q  <= {PTR_W{1'b0}};
            rsp_ptr_q  <= {PTR_W{1'b0}};
            slot_pc_q  <= '{default: {ADDR_W{1'b0}}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
            iss_ptr_q  <= iss_ptr_d;
            rsp_ptr_q  <= rsp_ptr_d;
            slot_pc_q  <= slot_pc_d;
        end
    end

    fetch_fifo #(
        .W     (INST_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data ({imem_resp_inst, slot_pc_q[rsp_ptr_q]}),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .rd_data   (head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    fetch_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .resp_valid (imem_resp_valid),
        .inflight   (inflight_q),
        .push       (push_s),
        .pop        (pop_s),
        .full       (fifo_full_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_q;
    assign out_valid      = !fifo_empty_s;
    assign out_inst       = head_s[ADDR_W +: INST_W];
    assign out_pc         = head_s[ADDR_W-1:0];
    assign out_pc_plus8   = fifo_empty_s ? {ADDR_W{1'b0}} : (head_s[ADDR_W-1:0] + LINK_A);
    assign occupancy      = fifo_count_s;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with an in-order fixed-latency memory model.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_inst, out_pc, out_pc_plus8;
    logic [2:0]  occupancy;

    int tests_run = 0;
    int fails     = 0;
    int lat       = 1;
    int cyc       = 0;

    typedef struct {logic [31:0] addr; int due;} mreq_t;
    mreq_t mq[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    fetch_queue_unit dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_inst(imem_resp_inst), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_pc_plus8(out_pc_plus8),
        .occupancy(occupancy)
    );

    // Memory: accepted requests answer lat edges later, in order; reset clears it.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) mq.delete();
        else if (imem_req_valid && imem_req_ready) mq.push_back('{addr: imem_req_addr, due: cyc + lat});
        #1;
        if (reset && mq.size() > 0 && mq[0].due <= cyc + 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_inst  = inst_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_inst  = 32'h0;
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({imem_req_valid, out_valid, out_inst, out_pc, out_pc_plus8, occupancy} !== 101'd0) begin
            fails++;
            $display("FAIL reset_outs: got v%b ov%b inst=%h pc=%h p8=%h occ=%0d exp all 0",
                     imem_req_valid, out_valid, out_inst, out_pc, out_pc_plus8, occupancy);
        end
        tests_run++;
        if (imem_req_addr !== 32'h0) begin
            fails++; $display("FAIL reset_addr: got %h exp 00000000", imem_req_addr);
        end
    endtask

    task automatic test_seq();
        int n = 0;
        reset = 1'b1;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        tests_run++;
        if (n !== 2) begin fails++; $display("FAIL seq_latency: got %0d cycles exp 2", n); end
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (!out_valid || out_pc !== 32'(4 * k) || out_pc_plus8 !== 32'(4 * k + 8)
                || out_inst !== inst_of(32'(4 * k))) begin
                fails++;
                $display("FAIL seq_head[%0d]: got v%b pc=%h p8=%h inst=%h exp pc=%h", k,
                         out_valid, out_pc, out_pc_plus8, out_inst, 32'(4 * k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (occupancy !== 3'd4 || imem_req_valid !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_full: got occ=%0d req_v=%b ov=%b exp occ=4 req_v=0 ov=1",
                     occupancy, imem_req_valid, out_valid);
        end
        tests_run++;
        if (out_pc !== 32'd24 || out_inst !== inst_of(32'd24)) begin
            fails++; $display("FAIL stall_head: got pc=%h exp 00000018", out_pc);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (!out_valid || out_pc !== 32'(24 + 4 * k) || out_inst !== inst_of(32'(24 + 4 * k))) begin
                fails++;
                $display("FAIL drain_head[%0d]: got v%b pc=%h exp pc=%h", k, out_valid, out_pc,
                         32'(24 + 4 * k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_stale();
        int n = 0;
        imem_req_ready = 1'b0;
        repeat (6) @(negedge clk);
        tests_run++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL stale_drained: got occ=%0d exp 0", occupancy);
        end
        lat = 3;
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b0) begin
            fails++; $display("FAIL redirect_noissue: got req_v=%b exp 0", imem_req_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++;
        if (imem_req_addr !== 32'h100 || out_valid !== 1'b0) begin
            fails++; $display("FAIL redirect_addr: got %h ov=%b exp 00000100 ov=0", imem_req_addr, out_valid);
        end
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        tests_run++;
        if (n !== 4 || out_pc !== 32'h100 || out_inst !== inst_of(32'h100)) begin
            fails++; $display("FAIL stale_first: got pc=%h after %0d exp 00000100 after 4", out_pc, n);
        end
        @(negedge clk);
        tests_run++;
        if (!out_valid || out_pc !== 32'h104) begin
            fails++; $display("FAIL stale_second: got v%b pc=%h exp 00000104", out_valid, out_pc);
        end
    endtask

    task automatic test_redirect_pop();
        int n = 0;
        @(negedge clk);
        tests_run++;
        if (!out_valid || out_pc !== 32'h108 || imem_resp_valid !== 1'b1) begin
            fails++;
            $display("FAIL rpop_pre: got v%b pc=%h resp_v=%b exp pc=00000108 resp_v=1",
                     out_valid, out_pc, imem_resp_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++;
        if (imem_req_addr !== 32'h200 || occupancy !== 3'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rpop_after: got addr=%h occ=%0d exp addr=00000200 occ=0", imem_req_addr, occupancy);
        end
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        tests_run++;
        if (out_pc !== 32'h200 || out_inst !== inst_of(32'h200)) begin
            fails++; $display("FAIL rpop_first: got pc=%h exp 00000200", out_pc);
        end
        @(negedge clk);
        tests_run++;
        if (!out_valid || out_pc !== 32'h204) begin
            fails++; $display("FAIL rpop_second: got v%b pc=%h exp 00000204", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++;
        if (imem_req_addr !== 32'hFFFF_FFFC) begin
            fails++; $display("FAIL wrap_addr0: got %h exp fffffffc", imem_req_addr);
        end
        @(negedge clk);
        tests_run++;
        if (imem_req_addr !== 32'h0) begin
            fails++; $display("FAIL wrap_addr1: got %h exp 00000000", imem_req_addr);
        end
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        tests_run++;
        if (out_pc !== 32'hFFFF_FFFC || out_pc_plus8 !== 32'h4 || out_inst !== inst_of(32'hFFFF_FFFC)) begin
            fails++; $display("FAIL wrap_head: got pc=%h p8=%h exp fffffffc/00000004", out_pc, out_pc_plus8);
        end
        @(negedge clk);
        tests_run++;
        if (!out_valid || out_pc !== 32'h0 || out_pc_plus8 !== 32'h8) begin
            fails++; $display("FAIL wrap_next: got v%b pc=%h p8=%h exp 00000000/00000008",
                              out_valid, out_pc, out_pc_plus8);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL rmid_pre: got ov=%b exp 1", out_valid); end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({imem_req_valid, out_valid, out_inst, out_pc, out_pc_plus8, occupancy} !== 101'd0
            || imem_req_addr !== 32'h0) begin
            fails++;
            $display("FAIL rmid_outs: got v%b ov%b inst=%h pc=%h p8=%h occ=%0d addr=%h exp all 0",
                     imem_req_valid, out_valid, out_inst, out_pc, out_pc_plus8, occupancy, imem_req_addr);
        end
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        tests_run++;
        if (out_pc !== 32'h0 || out_inst !== inst_of(32'h0)) begin
            fails++; $display("FAIL rmid_first: got pc=%h exp 00000000", out_pc);
        end
        @(negedge clk);
        tests_run++;
        if (!out_valid || out_pc !== 32'h4) begin
            fails++; $display("FAIL rmid_second: got v%b pc=%h exp 00000004", out_valid, out_pc);
        end
    endtask

    initial begin
        reset           = 1'b0;
        imem_req_ready  = 1'b1;
        out_ready       = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_resp_valid = 1'b0;
        imem_resp_inst  = 32'h0;
        test_reset();
        test_seq();
        test_stall();
        test_redirect_stale();
        test_redirect_pop();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
